// File: rtl/ysyx_22040386_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  ysyx_22040386_lsu_ctrl : MEM-stage load/store unit on a valid/ready bus
//  Rev 1.0
// ============================================================================
module ysyx_22040386_lsu_ctrl #(
   parameter int XLEN    = 64,
   parameter int AW      = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              i_LSU_clk,
   input  logic              i_LSU_rst_n,
   input  logic              i_LSU_valid,
   input  logic              i_LSU_MemRead,
   input  logic              i_LSU_MemWrite,
   input  logic [2:0]        i_LSU_mem_mask,
   input  logic [AW-1:0]     i_LSU_addr,
   input  logic [XLEN-1:0]   i_LSU_wdata,
   output logic              o_LSU_stall,
   output logic              o_LSU_done,
   output logic [XLEN-1:0]   o_LSU_rdata,
   output logic              o_LSU_misalign,
   output logic              o_LSU_err,
   output logic              o_LSU_req_valid,
   input  logic              i_LSU_req_ready,
   output logic              o_LSU_req_wen,
   output logic [AW-1:0]     o_LSU_req_addr,
   output logic [XLEN-1:0]   o_LSU_req_wdata,
   output logic [XLEN/8-1:0] o_LSU_req_wmask,
   input  logic              i_LSU_rsp_valid,
   input  logic [XLEN-1:0]   i_LSU_rsp_data,
   input  logic              i_LSU_rsp_err
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            wen_q;
   logic [AW-1:0]   addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [NB-1:0]   wmask_q;
   logic [1:0]      size_q;
   logic            zext_q;
   logic [OW-1:0]   off_q;
   logic [XLEN-1:0] rdata_q;
   logic            misal_q;
   logic            err_q;

   logic            w_access;
   logic [OW-1:0]   w_off;
   logic [1:0]      w_size;
   logic [3:0]      w_nbytes;
   logic            w_misal;
   logic [7:0]      w_base8;
   logic [NB-1:0]   w_wmask;
   logic [XLEN-1:0] w_sh;
   logic [XLEN-1:0] w_hi;
   logic            w_sign;
   logic [XLEN-1:0] w_ext;
   logic [CW-1:0]   w_cnt_inc;

   assign w_access  = i_LSU_valid & (i_LSU_MemRead | i_LSU_MemWrite);
   assign w_off     = i_LSU_addr[OW-1:0];
   assign w_size    = i_LSU_mem_mask[1:0];
   assign w_nbytes  = 4'd1 << w_size;
   // A doubleword on a 32-bit bus is wider than the bus and can never be aligned.
   assign w_misal   = ((4'(w_off) & (w_nbytes - 4'd1)) != 4'd0) | (w_nbytes > 4'(NB));
   assign w_cnt_inc = cnt_q + CW'(1);

   always_comb begin
      w_base8 = 8'h00;
      case (w_size)
         2'd0:    w_base8 = 8'h01;
         2'd1:    w_base8 = 8'h03;
         2'd2:    w_base8 = 8'h0F;
         default: w_base8 = 8'hFF;
      endcase
      w_wmask = NB'(w_base8) << w_off;
   end

   // Load extraction: w_hi marks the bits above the field, filled by sign or zero.
   assign w_sh = i_LSU_rsp_data >> {off_q, 3'b000};

   always_comb begin
      w_hi   = '0;
      w_sign = 1'b0;
      case (size_q)
         2'd0: begin
            w_hi   = {XLEN{1'b1}} << 8;
            w_sign = w_sh[7];
         end
         2'd1: begin
            w_hi   = {XLEN{1'b1}} << 16;
            w_sign = w_sh[15];
         end
         2'd2: begin
            w_hi   = {XLEN{1'b1}} << 32;
            w_sign = w_sh[31];
         end
         default: begin
            w_hi   = '0;
            w_sign = 1'b0;
         end
      endcase
      w_ext = (w_sh & ~w_hi) | ((w_sign & ~zext_q) ? w_hi : '0);
   end

   always_ff @(posedge i_LSU_clk or negedge i_LSU_rst_n) begin
      if (!i_LSU_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         size_q  <= 2'd0;
         zext_q  <= 1'b0;
         off_q   <= '0;
         rdata_q <= '0;
         misal_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         misal_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (w_access) begin
                  if (w_misal) begin
                     misal_q <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     wen_q   <= i_LSU_MemWrite;
                     addr_q  <= {i_LSU_addr[AW-1:OW], OW'(0)};
                     wdata_q <= i_LSU_wdata << {w_off, 3'b000};
                     wmask_q <= w_wmask;
                     size_q  <= w_size;
                     zext_q  <= i_LSU_mem_mask[2];
                     off_q   <= w_off;
                     state_q <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (i_LSU_req_ready) begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= w_cnt_inc;
               if (i_LSU_rsp_valid) begin
                  err_q   <= i_LSU_rsp_err;
                  state_q <= S_DONE;
                  if (!wen_q && !i_LSU_rsp_err) begin
                     rdata_q <= w_ext;
                  end
               end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                  err_q   <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Stall is forced low in reset so every output is quiet while rst_n is held.
   assign o_LSU_stall     = i_LSU_rst_n & (((state_q == S_IDLE) & w_access) |
                                           (state_q == S_REQ) | (state_q == S_WAIT));
   assign o_LSU_done      = (state_q == S_DONE);
   assign o_LSU_rdata     = rdata_q;
   assign o_LSU_misalign  = misal_q;
   assign o_LSU_err       = err_q;
   assign o_LSU_req_valid = (state_q == S_REQ);
   assign o_LSU_req_wen   = wen_q;
   assign o_LSU_req_addr  = addr_q;
   assign o_LSU_req_wdata = wdata_q;
   assign o_LSU_req_wmask = wmask_q;

endmodule
`default_nettype wire
